// File: rtl/mul_shiftadd_signed.sv
// Sequential shift-and-add multiplier, signed or unsigned operands.
// One multiplier bit is consumed per cycle. Operands are converted to
// magnitudes at load, and the sign is reapplied in one final step.
// The en/done handshake is level sensitive: en low clears the unit.
module mul_shiftadd_signed #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sign,
  output logic                  done,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PC_W = $clog2(DATA_W + 3) + 1;

  localparam logic [PC_W-1:0] PC_LOAD   = '0;
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(DATA_W);
  localparam logic [PC_W-1:0] PC_FIX    = PC_W'(DATA_W + 1);

  logic [PC_W-1:0]       pc_reg,    pc_next;
  logic [DATA_W-1:0]     mcand_reg, mcand_next;
  logic [2*DATA_W-1:0]   acc_reg,   acc_next;
  logic                  neg_reg,   neg_next;
  logic                  done_reg,  done_next;

  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W:0]       step_sum;

  // Operand magnitudes and the partial-sum adder, used by the load and step phases
  always_comb begin
    a_neg    = sign & multiplicand[DATA_W-1];
    b_neg    = sign & multiplier[DATA_W-1];
    a_mag    = a_neg ? (~multiplicand + 1'b1) : multiplicand;
    b_mag    = b_neg ? (~multiplier + 1'b1) : multiplier;
    step_sum = {1'b0, acc_reg[2*DATA_W-1:DATA_W]}
             + (acc_reg[0] ? {1'b0, mcand_reg} : {(DATA_W+1){1'b0}});
  end

  // Next-state selection by step counter; en low clears everything
  always_comb begin
    pc_next    = pc_reg;
    mcand_next = mcand_reg;
    acc_next   = acc_reg;
    neg_next   = neg_reg;
    done_next  = done_reg;
    if (!en) begin
      pc_next    = '0;
      mcand_next = '0;
      acc_next   = '0;
      neg_next   = 1'b0;
      done_next  = 1'b0;
    end else if (pc_reg == PC_LOAD) begin
      mcand_next = a_mag;
      acc_next   = {{DATA_W{1'b0}}, b_mag};
      neg_next   = a_neg ^ b_neg;
      pc_next    = pc_reg + 1'b1;
    end else if (pc_reg <= PC_LAST) begin
      // Low half doubles as the multiplier shift register
      acc_next   = {step_sum, acc_reg[DATA_W-1:1]};
      pc_next    = pc_reg + 1'b1;
    end else if (pc_reg == PC_FIX) begin
      acc_next   = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
      pc_next    = pc_reg + 1'b1;
    end else begin
      // Finished: counter and accumulator hold until en drops
      done_next  = 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      mcand_reg <= mcand_next;
      acc_reg   <= acc_next;
      neg_reg   <= neg_next;
      done_reg  <= done_next;
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: doc/mul_shiftadd_signed.md
# mul_shiftadd_signed

Sequential shift-and-add multiplier for signed or unsigned integers. It forms a 2·DATA_W-bit product from two DATA_W-bit operands in DATA_W+3 clock cycles, one bit of the multiplier per cycle. It is the multiplication companion to the subtract-shift divider and uses the same level-sensitive `en`/`done` handshake, so both units can sit behind one arithmetic-unit controller.

## Interface
- DATA_W, default 32: operand width in bits. Must be ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. High starts or continues an operation; low synchronously clears the unit.
- sign  in  1  1 = two's-complement operands, 0 = unsigned. Sampled at load only.
- done  out  1  product valid; stays high while `en` stays high.
- multiplicand  in  DATA_W  operand A. Sampled at load only.
- multiplier  in  DATA_W  operand B. Sampled at load only.
- product  out  2·DATA_W  result. Driven directly from the accumulator register.

## Operation
Internal state:
- pc: step counter, $clog2(DATA_W+3)+1 bits.
- mcand: DATA_W bits.
- acc: 2·DATA_W bits.
- neg: 1 bit.
- done register.

`product` = acc at all times. Before `done` it shows intermediate values; it is not valid until `done`=1.

On rst (async) or, at a clock edge, en=0: pc, acc, mcand, neg and done are all set to 0.

With en=1, at each edge, by pc value:
- pc=0 (load):
  - mcand ← (sign & A[MSB]) ? −A : A
  - acc ← {DATA_W'b0, (sign & B[MSB]) ? −B : B}
  - neg ← sign & (A[MSB] ^ B[MSB])
  - pc ← 1
- pc=1..DATA_W (step):
  - sum = {1'b0, acc[2W−1:W]} + (acc[0] ? {1'b0, mcand} : 0), DATA_W+1 bits.
  - acc ← {sum, acc[W−1:1]}
  - pc ← pc+1
- pc=DATA_W+1 (sign fix): acc ← neg ? −acc : acc (2·DATA_W-bit two's complement); pc ← pc+1.
- pc=DATA_W+2 (finish): done ← 1; pc holds; acc holds.

Arithmetic and width rules:
- Negation of −2^(DATA_W−1) yields 2^(DATA_W−1), which is correct when read as unsigned magnitude. All signed products are therefore exact, including (−2^(W−1))² = 2^(2W−2).
- No overflow is possible: the step sum carries into bit DATA_W, which is kept.

Boundary conditions:
- Operand or `sign` changes after the load edge are ignored until a new operation.
- A new operation requires en to go low for at least one edge, then high again.
- en dropping at any pc, including mid-step or after done, aborts and clears on that edge. No residue carries into the next operation.
- rst overrides en at any time.

## Timing
- Latency: `done` goes high after the (DATA_W+3)-th rising edge with en=1, counting the load edge as edge 1. For DATA_W=32 that is 35 edges.
- `product` is final at the same edge `done` rises, and holds until en=0 or rst.
- `done` falls on the first edge with en=0, or immediately on rst.
- No combinational path exists from inputs to outputs.
- Throughput: one product per DATA_W+4 cycles minimum, including one en-low clear cycle.
- Reset values: done=0, product=0.

## Test plan
All scenarios use DATA_W=32.
- Unsigned basic: sign=0, A=7, B=6, en held high → done rises on edge 35; product=0x0000_0000_0000_002A. done stays 1 and product is stable for 10 further edges.
- Signed mixed: sign=1, A=0xFFFF_FFF9 (−7), B=6 → product=0xFFFF_FFFF_FFFF_FFD6.
- Signed extremes:
  - A=B=0x8000_0000 → 0x4000_0000_0000_0000.
  - A=0x8000_0000, B=1 → 0xFFFF_FFFF_8000_0000.
  - A=0x7FFF_FFFF, B=0xFFFF_FFFF (−1) → 0xFFFF_FFFF_8000_0001.
- Unsigned extremes: sign=0, A=B=0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001. Same operands with sign=1 → 0x0000_0000_0000_0001.
- Abort and restart:
  - en low at pc=10 → next edge gives product=0, done=0.
  - Then en high with A=3, B=5 → 15 after 35 edges.
  - Changing A and B to random values after the load edge does not alter the result.
- Async reset: assert rst between edges mid-operation → done=0 and product=0 without waiting for a clock edge. Release rst with en=1 → a fresh operation starts at pc=0 and completes correctly.
